// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: screen geometry, pose types and sky colours shared by the frame sequencer.
package frame_sequencer_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam logic [2:0] SKY_COLOR     = 3'd5;
    localparam logic [2:0] SKY_COLOR_TOP = 3'd4;
    localparam logic [2:0] SKY_COLOR_LOW = 3'd6;
    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
    } screenXY;
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } posXY;
    typedef logic [9:0] angle;
    typedef enum logic [1:0] {CLEAR, KICK, RENDER, WAIT_SWAP} seq_state_e;
endpackage

// File: rtl/frame_sequencer_if.sv
// frame_sequencer_if: renderer handshake, latched pose and framebuffer write port.
interface frame_sequencer_if;
    import frame_sequencer_pkg::*;
    posXY        pos_out;
    angle        angle_out;
    logic        flight_out;
    logic [16:0] horizon_out;
    logic        render_ack;
    logic        render_done;
    screenXY     rend_coords;
    logic [2:0]  rend_color;
    logic        rend_we;
    screenXY     fb_coords;
    logic [2:0]  fb_color;
    logic        fb_we;
    modport master (
        output pos_out, angle_out, flight_out, horizon_out, render_ack, fb_coords, fb_color, fb_we,
        input  render_done, rend_coords, rend_color, rend_we
    );
    modport slave (
        input  pos_out, angle_out, flight_out, horizon_out, render_ack, fb_coords, fb_color, fb_we,
        output render_done, rend_coords, rend_color, rend_we
    );
endinterface

// File: rtl/frame_sequencer_sky_fill_counter.sv
// sky_fill_counter: raster x/y counter for the clear pass and its sky colour.
// SKY_GRADIENT_EN selects a three-band colour by row instead of a flat sky.
module sky_fill_counter
    import frame_sequencer_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       step_i,
    output screenXY    coords_o,
    output logic [2:0] color_o,
    output logic       start_o,
    output logic       last_o
);
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic       x_end, y_end;
    assign x_end    = x_q == 9'(SCREEN_W - 1);
    assign y_end    = y_q == 8'(SCREEN_H - 1);
    assign start_o  = x_q == '0 && y_q == '0;
    assign last_o   = x_end && y_end;
    assign coords_o = '{x: x_q, y: y_q};
    always_comb begin
        x_d = step_i ? (x_end ? '0 : x_q + 9'd1) : x_q;
        y_d = step_i && x_end ? (y_end ? '0 : y_q + 8'd1) : y_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
`ifdef SKY_GRADIENT_EN
    assign color_o = (y_q < 8'd80) ? SKY_COLOR_TOP : (y_q < 8'd160) ? SKY_COLOR : SKY_COLOR_LOW;
`else
    assign color_o = SKY_COLOR;
`endif
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame clear, pose latch, renderer kick and vsync buffer swap.
// Optional SKY_GRADIENT_EN gives a banded clear colour (see sky_fill_counter).
module frame_sequencer
    import frame_sequencer_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vsync_pulse,
    input  posXY              pos_in,
    input  angle              angle_in,
    input  logic              flight_in,
    input  logic [16:0]       horizon_in,
    frame_sequencer_if.master bus,
    output logic              back_sel,
    output logic              display_sel,
    output logic [15:0]       frame_count,
    output logic              overrun
);
    seq_state_e  state_q;
    logic        back_sel_q, ack_q, overrun_q, fb_we_q, flight_q;
    logic [15:0] frame_count_q;
    screenXY     fb_coords_q, cnt_coords;
    logic [2:0]  fb_color_q, cnt_color;
    posXY        pos_q;
    angle        angle_q;
    logic [16:0] horizon_q;
    logic        cnt_start, cnt_last, done_ok, swap, issue;

    // done is only honoured once the ack strobe has been seen by the renderer
    assign done_ok = state_q == RENDER && bus.render_done && !ack_q;
    assign swap    = vsync_pulse && (state_q == WAIT_SWAP || done_ok);
    assign issue   = state_q == CLEAR || (swap && cnt_start);

    sky_fill_counter u_fill (
        .Clk      (Clk),
        .Reset    (Reset),
        .step_i   (issue),
        .coords_o (cnt_coords),
        .color_o  (cnt_color),
        .start_o  (cnt_start),
        .last_o   (cnt_last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= CLEAR;
            back_sel_q    <= 1'b1;
            frame_count_q <= '0;
            ack_q         <= 1'b0;
            overrun_q     <= 1'b0;
            fb_we_q       <= 1'b0;
            fb_coords_q   <= '0;
            fb_color_q    <= '0;
            pos_q         <= '0;
            angle_q       <= '0;
            flight_q      <= 1'b0;
            horizon_q     <= '0;
        end else begin
            ack_q       <= state_q == KICK;
            overrun_q   <= vsync_pulse && !swap;
            fb_coords_q <= issue ? cnt_coords : bus.rend_coords;
            fb_color_q  <= issue ? cnt_color : bus.rend_color;
            fb_we_q     <= issue || (state_q == RENDER && bus.rend_we);
            if (swap) begin
                back_sel_q    <= !back_sel_q;
                frame_count_q <= frame_count_q + 16'd1;
                state_q       <= CLEAR;
            end else if (state_q == CLEAR && cnt_last) begin
                state_q <= KICK;
            end else if (state_q == KICK) begin
                state_q   <= RENDER;
                pos_q     <= pos_in;
                angle_q   <= angle_in;
                flight_q  <= flight_in;
                horizon_q <= horizon_in;
            end else if (done_ok) begin
                state_q <= WAIT_SWAP;
            end
        end
    end

    assign bus.render_ack  = ack_q;
    assign bus.fb_we       = fb_we_q;
    assign bus.fb_coords   = fb_coords_q;
    assign bus.fb_color    = fb_color_q;
    assign bus.pos_out     = pos_q;
    assign bus.angle_out   = angle_q;
    assign bus.flight_out  = flight_q;
    assign bus.horizon_out = horizon_q;
    assign back_sel        = back_sel_q;
    assign display_sel     = !back_sel_q;
    assign frame_count     = frame_count_q;
    assign overrun         = overrun_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: clear sweep, renderer write table, overrun and swap sequences for frame_sequencer.
module tb_frame_sequencer;
    import frame_sequencer_pkg::*;
    logic        Clk = 1'b0;
    logic        Reset, vsync_pulse, flight_in;
    posXY        pos_in;
    angle        angle_in;
    logic [16:0] horizon_in;
    logic        back_sel, display_sel, overrun;
    logic [15:0] frame_count;
    int          vectors = 0, miscompares = 0;

    frame_sequencer_if bus();

    frame_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .vsync_pulse (vsync_pulse),
        .pos_in      (pos_in),
        .angle_in    (angle_in),
        .flight_in   (flight_in),
        .horizon_in  (horizon_in),
        .bus         (bus),
        .back_sel    (back_sel),
        .display_sel (display_sel),
        .frame_count (frame_count),
        .overrun     (overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       we;
    } rvec_t;

`ifdef SKY_GRADIENT_EN
    localparam logic [2:0] E79 = 3'd4, E80 = 3'd5, E160 = 3'd6;
`else
    localparam logic [2:0] E79 = 3'd5, E80 = 3'd5, E160 = 3'd5;
`endif

    function automatic logic [2:0] sky(input int y);
`ifdef SKY_GRADIENT_EN
        return y < 80 ? 3'd4 : y < 160 ? 3'd5 : 3'd6;
`else
        return 3'd5;
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic new_pose();
        pos_in     = '{x: 16'($urandom), y: 16'($urandom)};
        angle_in   = 10'($urandom);
        flight_in  = 1'($urandom);
        horizon_in = 17'($urandom);
    endtask

    rvec_t       tbl[8];
    posXY        exp_pos;
    angle        exp_ang;
    logic        exp_flt;
    logic [16:0] exp_hor;
    logic [2:0]  c79, c80, c160;
    int          bad, we_cnt;

    initial begin
        tbl[0] = '{9'd10,  8'd20,  3'd3, 1'b1};
        tbl[1] = '{9'd0,   8'd0,   3'd7, 1'b1};
        tbl[2] = '{9'd319, 8'd239, 3'd1, 1'b1};
        tbl[3] = '{9'd5,   8'd5,   3'd2, 1'b0};
        tbl[4] = '{9'd11,  8'd20,  3'd3, 1'b1};
        tbl[5] = '{9'd12,  8'd20,  3'd3, 1'b1};
        tbl[6] = '{9'd100, 8'd200, 3'd0, 1'b1};
        tbl[7] = '{9'd0,   8'd0,   3'd0, 1'b0};
        Reset = 1'b1;
        vsync_pulse = 1'b0;
        bus.render_done = 1'b0;
        bus.rend_coords = '0;
        bus.rend_color = '0;
        bus.rend_we = 1'b0;
        new_pose();
        repeat (3) tick();
        check("rst_back_sel", back_sel, 1);
        check("rst_display_sel", display_sel, 0);
        check("rst_fb_we", bus.fb_we, 0);
        check("rst_ack", bus.render_ack, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_pos_out", bus.pos_out, 0);
        Reset = 1'b0;

        bad = 0;
        we_cnt = 0;
        for (int i = 0; i < SCREEN_W * SCREEN_H; i++) begin
            tick();
            we_cnt += int'(bus.fb_we);
            if (!(bus.fb_we === 1'b1 && bus.fb_coords.x == 9'(i % 320) && bus.fb_coords.y == 8'(i / 320)
                  && bus.fb_color == sky(i / 320) && bus.render_ack === 1'b0 && back_sel === 1'b1))
                bad++;
            if (i == 79 * 320) c79 = bus.fb_color;
            if (i == 80 * 320) c80 = bus.fb_color;
            if (i == 160 * 320) c160 = bus.fb_color;
            if (i == 1001) check("ovr_clear", overrun, 1);
            if (i == 1002) check("ovr_clear_end", overrun, 0);
            vsync_pulse = i == 1000;
            bus.render_done = i == 2000;
            new_pose();
        end
        exp_pos = pos_in;
        exp_ang = angle_in;
        exp_flt = flight_in;
        exp_hor = horizon_in;
        check("clear_bad_pixels", bad, 0);
        check("clear_we_cycles", we_cnt, 76800);
        check("row79_color", c79, E79);
        check("row80_color", c80, E80);
        check("row160_color", c160, E160);

        tick();
        check("kick_ack", bus.render_ack, 1);
        check("kick_fb_we", bus.fb_we, 0);
        check("kick_pos", bus.pos_out, exp_pos);
        check("kick_angle", bus.angle_out, exp_ang);
        check("kick_flight", bus.flight_out, exp_flt);
        check("kick_horizon", bus.horizon_out, exp_hor);
        new_pose();
        tick();
        check("ack_one_cycle", bus.render_ack, 0);

        for (int k = 0; k < 8; k++) begin
            bus.rend_coords = '{x: tbl[k].x, y: tbl[k].y};
            bus.rend_color = tbl[k].c;
            bus.rend_we = tbl[k].we;
            new_pose();
            tick();
            check($sformatf("tbl%0d_we", k), bus.fb_we, tbl[k].we);
            if (tbl[k].we) begin
                check($sformatf("tbl%0d_xy", k), {bus.fb_coords.x, bus.fb_coords.y}, {tbl[k].x, tbl[k].y});
                check($sformatf("tbl%0d_col", k), bus.fb_color, tbl[k].c);
            end
        end
        for (int k = 0; k < 20; k++) begin
            rvec_t r;
            r = '{9'($urandom_range(319)), 8'($urandom_range(239)), 3'($urandom), 1'($urandom)};
            bus.rend_coords = '{x: r.x, y: r.y};
            bus.rend_color = r.c;
            bus.rend_we = r.we;
            tick();
            check("rnd_we", bus.fb_we, r.we);
            if (r.we) check("rnd_px", {bus.fb_coords.x, bus.fb_coords.y, bus.fb_color}, {r.x, r.y, r.c});
        end
        check("render_pos_hold", bus.pos_out, exp_pos);
        check("render_hor_hold", bus.horizon_out, exp_hor);

        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check("ovr_render", overrun, 1);
        check("ovr_no_swap", back_sel, 1);
        check("ovr_no_count", frame_count, 0);
        tick();
        check("ovr_render_end", overrun, 0);

        bus.render_done = 1'b1;
        bus.rend_we = 1'b0;
        tick();
        bus.render_done = 1'b0;
        check("wait_fb_we", bus.fb_we, 0);
        for (int k = 0; k < 4; k++) begin
            bus.rend_we = 1'b1;
            bus.render_done = k == 1;
            tick();
            check("wait_fb_we_hold", bus.fb_we, 0);
        end
        bus.render_done = 1'b0;
        bus.rend_we = 1'b0;
        check("wait_no_swap", back_sel, 1);

        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check("swap_back_sel", back_sel, 0);
        check("swap_display_sel", display_sel, 1);
        check("swap_frame_count", frame_count, 1);
        check("swap_overrun", overrun, 0);
        check("swap_fb_we", bus.fb_we, 1);
        check("swap_first_px", {bus.fb_coords.x, bus.fb_coords.y, bus.fb_color}, {9'd0, 8'd0, sky(0)});
        tick();
        check("swap_second_px", {bus.fb_coords.x, bus.fb_coords.y}, {9'd1, 8'd0});
        check("swap_pos_hold", bus.pos_out, exp_pos);

        repeat (500) tick();
        check("clear2_px", {bus.fb_we, bus.fb_coords.x, bus.fb_coords.y}, {1'b1, 9'd181, 8'd1});
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
        check("ovr_clear2", overrun, 1);
        check("ovr_clear2_sel", display_sel, 1);

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_back_sel", back_sel, 1);
        check("mid_rst_count", frame_count, 0);
        check("mid_rst_fb_we", bus.fb_we, 0);
        check("mid_rst_pos", bus.pos_out, 0);
        tick();
        check("mid_rst_first_px", {bus.fb_we, bus.fb_coords.x, bus.fb_coords.y}, {1'b1, 9'd0, 8'd0});
        tick();
        check("mid_rst_second_px", {bus.fb_we, bus.fb_coords.x, bus.fb_coords.y}, {1'b1, 9'd1, 8'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
